lap_stopwatch: RTL and testbench
================================

// Module: lap_stopwatch
//
// PURPOSE
//   Parametrised up/down stopwatch with pause/resume and a lap-capture FIFO.
//   Counts modulo MAX+1 while running; a lap strobe snapshots the count into a
//   LAP_DEPTH-entry first-word-fall-through queue drained by the host.
//   Sits beside control logic that needs split times without stalling the counter.
//
// PARAMETERS
//   DATA_WIDTH  16  width of count and lap entries
//   MAX         99  terminal count; count range 0..MAX; MAX < 2**DATA_WIDTH
//   LAP_DEPTH   4   lap FIFO entries; power of two, >= 2
//
// PORTS
//   clk          in   1           single clock, all logic on posedge
//   reset        in   1           synchronous, active-high
//   start        in   1           begin (from IDLE) or resume (from PAUSE)
//   stop         in   1           pause counting; dominates start
//   down         in   1           direction, sampled only on start from IDLE
//   lap          in   1           push current count into lap FIFO
//   lap_rd       in   1           pop lap FIFO head
//   count        out  DATA_WIDTH  current count
//   running      out  1           1 in RUN state
//   wrap         out  1           1-cycle pulse on MAX->0 (up) or 0->MAX (down)
//   lap_data     out  DATA_WIDTH  FIFO head, valid when lap_valid
//   lap_valid    out  1           FIFO non-empty
//   lap_full     out  1           FIFO holds LAP_DEPTH entries
//   lap_overflow out  1           sticky: a lap was dropped while full
//
// BEHAVIOUR
//   - Reset: count=0, state=IDLE, dir=up, running=0, wrap=0, FIFO empty,
//     lap_data=0, lap_valid=0, lap_full=0, lap_overflow=0. Reset mid-run
//     discards all laps and state in one cycle.
//   - States: IDLE -(start & !stop)-> RUN (latch dir=down);
//     RUN -(stop)-> PAUSE; PAUSE -(start & !stop)-> RUN (dir kept);
//     stop in IDLE/PAUSE: no change. IDLE re-entered only by reset.
//   - Priority per cycle: reset > stop > start > hold.
//   - Counting: update occurs in the start cycle and every RUN cycle without
//     stop (count visible +1/-1 one cycle after start). Up: MAX->0 else +1.
//     Down: 0->MAX else -1. stop cycle: count holds.
//   - wrap registered with the count update that wraps; 0 otherwise.
//   - Lap push captures count as seen on the output in the lap cycle (pre-
//     update value); allowed in any state. Push when full and no pop:
//     entry dropped, lap_overflow<=1 until reset. Push and pop same cycle
//     when full: both occur, no overflow. Push+pop when empty: entry written,
//     lap_valid=1 next cycle. Pop when empty: ignored.
//   - FWFT: lap_data = oldest entry, stable until popped.
//   - Pointers log2(LAP_DEPTH)+1 bits; full/empty from MSB compare.
//
// STRUCTURE
//   - Package stopwatch_pkg: typedef enum logic [1:0] sw_state_e
//     {SW_IDLE, SW_RUN, SW_PAUSE}; shared with other timer blocks.
//   - Sub-module lap_fifo #(DATA_WIDTH, LAP_DEPTH): sync FWFT FIFO with
//     push/pop/data/valid/full/overflow; top holds FSM and counter.
//
// TESTING
//   1 reset; start 1 cyc, up -> count 1,2,3...; at 99 next count 0, wrap=1 1 cyc
//   2 run to 5; stop -> holds 5 for 10 cyc, running=0; start -> 6 next cyc
//   3 reset; down=1,start -> count 99 with wrap=1, then 98; pause, down=0,
//     start -> continues 97 (dir not re-sampled)
//   4 laps at counts 3,7,12,20,25 without pops -> FIFO 3,7,12,20, lap_full=1,
//     lap_overflow=1; pop x4 -> lap_data 3,7,12,20 then lap_valid=0
//   5 full FIFO, lap & lap_rd same cycle -> no overflow, new entry at tail
//   6 start & stop same cycle from IDLE -> stays IDLE, count 0; reset while
//     running with 2 laps -> all outputs to reset values next cycle

Source files
------------

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
//   Shared definitions for the timer family. The state encoding is used by
//   lap_stopwatch and is meant to be reused by sibling timer blocks.
//   No ports; import with "import stopwatch_pkg::*;".
package stopwatch_pkg;

  // Stopwatch control states. IDLE is left on the first start and is only
  // re-entered through reset; PAUSE keeps the latched direction.
  typedef enum logic [1:0] {
    SW_IDLE  = 2'd0,
    SW_RUN   = 2'd1,
    SW_PAUSE = 2'd2
  } sw_state_e;

endpackage

// File: rtl/lap_fifo.sv
// lap_fifo
//   Synchronous first-word-fall-through FIFO holding captured lap times.
//   Ports:
//     clk      in   posedge clock
//     reset    in   synchronous active-high reset, empties the queue
//     push     in   write wdata at the tail
//     pop      in   drop the head entry (ignored when empty)
//     wdata    in   value to capture
//     data     out  head entry, forced to 0 while empty
//     valid    out  queue non-empty
//     full     out  queue holds LAP_DEPTH entries
//     overflow out  sticky flag, set when a push is dropped while full
module lap_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int LAP_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic                  full,
  output logic                  overflow
);

  localparam int AW = $clog2(LAP_DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]           r_wrPtr;
  logic [AW:0]           r_rdPtr;
  logic [DATA_WIDTH-1:0] r_mem [LAP_DEPTH];
  logic                  r_overflow;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_doPush;
  logic                  w_doPop;

  assign w_empty = (r_wrPtr == r_rdPtr);
  assign w_full  = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                   (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);

  // A push into a full queue still succeeds when the head leaves in the same
  // cycle; a pop on an empty queue is ignored even if a push arrives with it.
  assign w_doPush = push && (!w_full || pop);
  assign w_doPop  = pop && !w_empty;

  // Pointer and sticky-overflow bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      if (push && w_full && !pop) r_overflow <= 1'b1;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever empty.
  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr[AW-1:0]] <= wdata;
  end

  assign data     = w_empty ? '0 : r_mem[r_rdPtr[AW-1:0]];
  assign valid    = !w_empty;
  assign full     = w_full;
  assign overflow = r_overflow;

endmodule

// File: rtl/lap_stopwatch.sv
// lap_stopwatch
//   Up/down modulo-(MAX+1) stopwatch with pause/resume and a lap-capture FIFO.
//   Ports:
//     clk          in   posedge clock
//     reset        in   synchronous active-high reset
//     start        in   begin from IDLE (latches down) or resume from PAUSE
//     stop         in   pause counting, wins over start
//     down         in   count direction, sampled only when leaving IDLE
//     lap          in   capture the displayed count into the lap FIFO
//     lap_rd       in   pop the lap FIFO head
//     count        out  current count, 0..MAX
//     running      out  high in RUN
//     wrap         out  one-cycle pulse with the update that wraps
//     lap_data     out  oldest lap entry (0 when empty)
//     lap_valid    out  lap FIFO non-empty
//     lap_full     out  lap FIFO full
//     lap_overflow out  sticky, a lap was dropped
module lap_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int MAX        = 99,
  parameter int LAP_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  down,
  input  logic                  lap,
  input  logic                  lap_rd,
  output logic [DATA_WIDTH-1:0] count,
  output logic                  running,
  output logic                  wrap,
  output logic [DATA_WIDTH-1:0] lap_data,
  output logic                  lap_valid,
  output logic                  lap_full,
  output logic                  lap_overflow
);

  localparam logic [DATA_WIDTH-1:0] L_MAX = DATA_WIDTH'(MAX);

  sw_state_e             r_state;
  sw_state_e             w_nextState;
  logic                  r_down;
  logic                  w_dirDown;
  logic                  w_countEn;
  logic                  w_atWrap;
  logic [DATA_WIDTH-1:0] r_count;
  logic [DATA_WIDTH-1:0] w_nextCount;
  logic                  r_wrap;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= SW_IDLE;
    else       r_state <= w_nextState;
  end

  // Next-state logic: stop always wins over start.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      SW_IDLE:  if (start && !stop) w_nextState = SW_RUN;
      SW_RUN:   if (stop)           w_nextState = SW_PAUSE;
      SW_PAUSE: if (start && !stop) w_nextState = SW_RUN;
      default:                      w_nextState = SW_IDLE;
    endcase
  end

  // Outputs of the FSM. The counter advances in exactly the cycles whose
  // next state is RUN, which covers the start cycle and every unstopped RUN
  // cycle. Leaving IDLE uses the live down input, afterwards the latched one.
  always_comb begin
    running   = (r_state == SW_RUN);
    w_countEn = (w_nextState == SW_RUN);
    w_dirDown = (r_state == SW_IDLE) ? down : r_down;
  end

  // Direction is captured once, on the transition out of IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_down <= 1'b0;
    end else if (r_state == SW_IDLE && w_nextState == SW_RUN) begin
      r_down <= down;
    end
  end

  // Modulo step in the active direction.
  always_comb begin
    w_atWrap    = w_dirDown ? (r_count == '0) : (r_count == L_MAX);
    w_nextCount = '0;
    if (w_dirDown) w_nextCount = w_atWrap ? L_MAX : r_count - 1'b1;
    else           w_nextCount = w_atWrap ? '0    : r_count + 1'b1;
  end

  // Count register; wrap is registered alongside the update that wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else if (w_countEn) begin
      r_count <= w_nextCount;
      r_wrap  <= w_atWrap;
    end else begin
      r_wrap  <= 1'b0;
    end
  end

  assign count = r_count;
  assign wrap  = r_wrap;

  // Laps capture the count currently on the output, before this cycle's step.
  lap_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .LAP_DEPTH  (LAP_DEPTH)
  ) u_lapFifo (
    .clk      (clk),
    .reset    (reset),
    .push     (lap),
    .pop      (lap_rd),
    .wdata    (r_count),
    .data     (lap_data),
    .valid    (lap_valid),
    .full     (lap_full),
    .overflow (lap_overflow)
  );

endmodule

// File: tb/tb_lap_stopwatch.sv
module tb_lap_stopwatch;

  localparam int DW    = 16;
  localparam int MAXV  = 99;
  localparam int DEPTH = 4;

  logic          clk;
  logic          reset;
  logic          start;
  logic          stop;
  logic          down;
  logic          lap;
  logic          lapRd;
  logic [DW-1:0] count;
  logic          running;
  logic          wrap;
  logic [DW-1:0] lapData;
  logic          lapValid;
  logic          lapFull;
  logic          lapOverflow;

  int assertCount = 0;
  int failCount   = 0;

  // Behavioural reference: plain integers plus a queue of lap values.
  int mCount;
  bit mRun;
  bit mStarted;
  bit mDown;
  bit mWrap;
  bit mOvf;
  int lapQ[$];

  typedef struct {
    logic rst;
    logic start;
    logic stop;
    logic down;
    int   expCount;
    logic expRunning;
    logic expWrap;
  } vec_t;

  vec_t vecs[9];

  lap_stopwatch #(
    .DATA_WIDTH (DW),
    .MAX        (MAXV),
    .LAP_DEPTH  (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .down         (down),
    .lap          (lap),
    .lap_rd       (lapRd),
    .count        (count),
    .running      (running),
    .wrap         (wrap),
    .lap_data     (lapData),
    .lap_valid    (lapValid),
    .lap_full     (lapFull),
    .lap_overflow (lapOverflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    assertCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Advance the reference by one clock using the stopwatch rules directly.
  task automatic modelStep(input bit r, input bit s, input bit p, input bit d,
                           input bit l, input bit rd);
    bit advance;
    if (r) begin
      mCount = 0; mRun = 0; mStarted = 0; mDown = 0; mWrap = 0; mOvf = 0;
      lapQ.delete();
    end else begin
      if (rd && lapQ.size() > 0) void'(lapQ.pop_front());
      if (l) begin
        if (lapQ.size() < DEPTH) lapQ.push_back(mCount);
        else                     mOvf = 1;
      end
      advance = !p && (mRun || s);
      if (advance && !mStarted) mDown = d;
      if (advance) begin
        mStarted = 1;
        mRun     = 1;
      end else if (p) begin
        mRun = 0;
      end
      if (advance) begin
        if (mDown) begin
          mWrap  = (mCount == 0);
          mCount = (mCount == 0) ? MAXV : mCount - 1;
        end else begin
          mWrap  = (mCount == MAXV);
          mCount = (mCount == MAXV) ? 0 : mCount + 1;
        end
      end else begin
        mWrap = 0;
      end
    end
  endtask

  // Drive one cycle of inputs, step the model, compare every output.
  task automatic applyStimulus(input bit r, input bit s, input bit p, input bit d,
                               input bit l, input bit rd);
    reset = r; start = s; stop = p; down = d; lap = l; lapRd = rd;
    @(posedge clk);
    modelStep(r, s, p, d, l, rd);
    #1;
    checkOutput("model.count",    int'(count),       mCount);
    checkOutput("model.running",  int'(running),     int'(mRun));
    checkOutput("model.wrap",     int'(wrap),        int'(mWrap));
    checkOutput("model.lapValid", int'(lapValid),    int'(lapQ.size() > 0));
    checkOutput("model.lapData",  int'(lapData),     (lapQ.size() > 0) ? lapQ[0] : 0);
    checkOutput("model.lapFull",  int'(lapFull),     int'(lapQ.size() == DEPTH));
    checkOutput("model.overflow", int'(lapOverflow), int'(mOvf));
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  // Run until the reference reaches target, bounded.
  task automatic runUntil(input int target);
    int guard = 0;
    while (mCount != target && guard < 300) begin
      idle();
      guard++;
    end
    checkOutput("runUntil.reach", int'(count), target);
  endtask

  initial begin
    int expLaps[4];
    reset = 1; start = 0; stop = 0; down = 0; lap = 0; lapRd = 0;

    // Table: reset, start&stop in IDLE, run, stop&start, resume ignoring down.
    vecs[0] = '{1, 0, 0, 0, 0, 0, 0};
    vecs[1] = '{0, 1, 1, 0, 0, 0, 0};
    vecs[2] = '{0, 1, 0, 0, 1, 1, 0};
    vecs[3] = '{0, 0, 0, 0, 2, 1, 0};
    vecs[4] = '{0, 0, 0, 0, 3, 1, 0};
    vecs[5] = '{0, 1, 1, 0, 3, 0, 0};
    vecs[6] = '{0, 0, 0, 0, 3, 0, 0};
    vecs[7] = '{0, 1, 0, 1, 4, 1, 0};
    vecs[8] = '{0, 0, 1, 0, 4, 0, 0};

    $display("[TB] table vectors");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].start, vecs[i].stop, vecs[i].down, 0, 0);
      checkOutput("vec.count",   int'(count),   vecs[i].expCount);
      checkOutput("vec.running", int'(running), int'(vecs[i].expRunning));
      checkOutput("vec.wrap",    int'(wrap),    int'(vecs[i].expWrap));
    end

    $display("[TB] up count and wrap");
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("reset.count",    int'(count),       0);
    checkOutput("reset.lapValid", int'(lapValid),    0);
    checkOutput("reset.overflow", int'(lapOverflow), 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("up.first", int'(count), 1);
    idle();
    checkOutput("up.second", int'(count), 2);
    runUntil(MAXV);
    idle();
    checkOutput("up.wrapCount", int'(count), 0);
    checkOutput("up.wrapPulse", int'(wrap),  1);
    idle();
    checkOutput("up.afterWrap", int'(count), 1);
    checkOutput("up.wrapDone",  int'(wrap),  0);

    $display("[TB] pause and resume");
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    runUntil(5);
    applyStimulus(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      idle();
      checkOutput("pause.hold",    int'(count),   5);
      checkOutput("pause.running", int'(running), 0);
    end
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("pause.resume", int'(count), 6);

    $display("[TB] down count");
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 0, 0);
    checkOutput("down.wrapCount", int'(count), MAXV);
    checkOutput("down.wrapPulse", int'(wrap),  1);
    idle();
    checkOutput("down.next", int'(count), 98);
    applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("down.keepDir", int'(count), 97);

    $display("[TB] lap overflow and drain");
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    runUntil(3);  applyStimulus(0, 0, 0, 0, 1, 0);
    runUntil(7);  applyStimulus(0, 0, 0, 0, 1, 0);
    runUntil(12); applyStimulus(0, 0, 0, 0, 1, 0);
    runUntil(20); applyStimulus(0, 0, 0, 0, 1, 0);
    runUntil(25); applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("lap.full",     int'(lapFull),     1);
    checkOutput("lap.overflow", int'(lapOverflow), 1);
    applyStimulus(0, 0, 1, 0, 0, 0);
    expLaps = '{3, 7, 12, 20};
    for (int i = 0; i < 4; i++) begin
      checkOutput("lap.head", int'(lapData), expLaps[i]);
      applyStimulus(0, 0, 0, 0, 0, 1);
    end
    checkOutput("lap.drained", int'(lapValid), 0);

    $display("[TB] push and pop on full");
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    runUntil(2); applyStimulus(0, 0, 0, 0, 1, 0);
    runUntil(4); applyStimulus(0, 0, 0, 0, 1, 0);
    runUntil(6); applyStimulus(0, 0, 0, 0, 1, 0);
    runUntil(8); applyStimulus(0, 0, 0, 0, 1, 0);
    runUntil(10);
    applyStimulus(0, 0, 0, 0, 1, 1);
    checkOutput("both.overflow", int'(lapOverflow), 0);
    checkOutput("both.full",     int'(lapFull),     1);
    expLaps = '{4, 6, 8, 10};
    for (int i = 0; i < 4; i++) begin
      checkOutput("both.head", int'(lapData), expLaps[i]);
      applyStimulus(0, 0, 0, 0, 0, 1);
    end
    checkOutput("both.drained", int'(lapValid), 0);

    $display("[TB] reset mid-run with laps");
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    runUntil(2); applyStimulus(0, 0, 0, 0, 1, 0);
    runUntil(4); applyStimulus(0, 0, 0, 0, 1, 0);
    runUntil(6);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("rst.count",    int'(count),       0);
    checkOutput("rst.running",  int'(running),     0);
    checkOutput("rst.wrap",     int'(wrap),        0);
    checkOutput("rst.lapData",  int'(lapData),     0);
    checkOutput("rst.lapValid", int'(lapValid),    0);
    checkOutput("rst.lapFull",  int'(lapFull),     0);
    checkOutput("rst.overflow", int'(lapOverflow), 0);

    $display("[TB] random traffic");
    for (int i = 0; i < 800; i++) begin
      applyStimulus(($urandom % 64) == 0, ($urandom % 4) == 0, ($urandom % 10) == 0,
                    1'($urandom), ($urandom % 4) == 0, ($urandom % 3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
